sys_cmd_host: RTL and testbench

//  Host-side command initiator: the far end of the UART command link into SYS_CNTRL.

---
 rtl/sys_cmd_host.sv | 199 +++++++++++++++++++
 tb/tb_sys_cmd_host.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_host.sv
// Host-side command initiator for the SYS_CNTRL UART link.
// Serialises one accepted command into its byte frame on a TX byte stream,
// then collects the LSB-first response from an RX byte stream, aborting
// with a timeout pulse when the gap between response bytes grows too long.
module sys_cmd_host #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_SIZE      = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int RSP_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMR_WIDTH      = 13
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_TYPE,
  input  logic [ADDR_SIZE-1:0]     CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]    CMD_A,
  input  logic [DATA_WIDTH-1:0]    CMD_B,
  input  logic [ALU_FUN_WIDTH-1:0] CMD_FUN,
  output logic [DATA_WIDTH-1:0]    TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_READY,
  input  logic [DATA_WIDTH-1:0]    RX_DATA,
  input  logic                     RX_VALID,
  output logic [RSP_WIDTH-1:0]     RSP_DATA,
  output logic                     RSP_VALID,
  output logic                     TIMEOUT_ERR,
  output logic                     BUSY
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_RSP = 2'd2} state_t;

  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] frame     [4];
  logic [DATA_WIDTH-1:0] frame_nxt [4];
  logic [1:0]            last_idx, last_idx_nxt;   // index of the final frame byte
  logic [1:0]            rsp_len, rsp_len_nxt;     // response bytes expected (0..2)
  logic [1:0]            byte_idx, byte_idx_nxt;
  logic                  rx_cnt, rx_cnt_nxt;       // response bytes received so far
  logic [TMR_WIDTH-1:0]  timer, timer_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt;
  logic                  tx_valid_nxt;
  logic [RSP_WIDTH-1:0]  rsp_data_nxt;
  logic                  rsp_valid_nxt;
  logic                  timeout_err_nxt;

  logic                  accept;
  logic                  tx_fire;
  logic                  tx_last;
  logic                  rx_last;
  logic                  tmr_exp;
  logic [DATA_WIDTH-1:0] addr_byte;
  logic [DATA_WIDTH-1:0] fun_byte;

  assign accept    = CMD_VALID && CMD_READY;
  assign tx_fire   = TX_VALID && TX_READY;
  assign tx_last   = (byte_idx == last_idx);
  assign rx_last   = ({1'b0, rx_cnt} == (rsp_len - 2'd1));
  assign tmr_exp   = (timer == TMR_LAST);
  assign addr_byte = DATA_WIDTH'(CMD_ADDR);
  assign fun_byte  = DATA_WIDTH'(CMD_FUN);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode: accept -> stream frame -> optional response wait.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SEND;
      SEND:     if (tx_fire && tx_last) state_nxt = (rsp_len == 2'd0) ? IDLE : WAIT_RSP;
      WAIT_RSP: if (RX_VALID ? rx_last : tmr_exp) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values for the frame store, counters and every registered output.
  always_comb begin
    frame_nxt       = frame;
    last_idx_nxt    = last_idx;
    rsp_len_nxt     = rsp_len;
    byte_idx_nxt    = byte_idx;
    rx_cnt_nxt      = rx_cnt;
    timer_nxt       = timer;
    tx_data_nxt     = TX_DATA;
    tx_valid_nxt    = TX_VALID;
    rsp_data_nxt    = RSP_DATA;
    rsp_valid_nxt   = 1'b0;
    timeout_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          // Unused trailing frame slots are simply never transmitted.
          case (CMD_TYPE)
            2'd0: begin
              frame_nxt[0] = DATA_WIDTH'(8'hAA);
              frame_nxt[1] = addr_byte;
              frame_nxt[2] = CMD_A;
              last_idx_nxt = 2'd2;
              rsp_len_nxt  = 2'd0;
            end
            2'd1: begin
              frame_nxt[0] = DATA_WIDTH'(8'hBB);
              frame_nxt[1] = addr_byte;
              last_idx_nxt = 2'd1;
              rsp_len_nxt  = 2'd1;
            end
            2'd2: begin
              frame_nxt[0] = DATA_WIDTH'(8'hCC);
              frame_nxt[1] = CMD_A;
              frame_nxt[2] = CMD_B;
              frame_nxt[3] = fun_byte;
              last_idx_nxt = 2'd3;
              rsp_len_nxt  = 2'd2;
            end
            default: begin
              frame_nxt[0] = DATA_WIDTH'(8'hDD);
              frame_nxt[1] = fun_byte;
              last_idx_nxt = 2'd1;
              rsp_len_nxt  = 2'd2;
            end
          endcase
          byte_idx_nxt = 2'd0;
          rsp_data_nxt = '0;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = frame_nxt[0];
        end
      end
      SEND: begin
        if (tx_fire) begin
          if (tx_last) begin
            tx_valid_nxt  = 1'b0;
            timer_nxt     = '0;
            rx_cnt_nxt    = 1'b0;
            rsp_valid_nxt = (rsp_len == 2'd0);
          end else begin
            byte_idx_nxt = byte_idx + 2'd1;
            tx_data_nxt  = frame[byte_idx_nxt];
          end
        end
      end
      WAIT_RSP: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (RX_VALID) begin
          timer_nxt = '0;
          if (rx_cnt) rsp_data_nxt[2*DATA_WIDTH-1:DATA_WIDTH] = RX_DATA;
          else        rsp_data_nxt[DATA_WIDTH-1:0]            = RX_DATA;
          rx_cnt_nxt    = 1'b1;
          rsp_valid_nxt = rx_last;
        end else if (tmr_exp) begin
          timeout_err_nxt = 1'b1;
        end else begin
          timer_nxt = timer + TMR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Register outputs and counters; the frame store holds plain data and needs no reset.
  always_ff @(posedge CLK) begin
    frame <= frame_nxt;
    if (!RST) begin
      TX_DATA     <= '0;
      TX_VALID    <= 1'b0;
      RSP_DATA    <= '0;
      RSP_VALID   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      BUSY        <= 1'b0;
      CMD_READY   <= 1'b1;
      last_idx    <= 2'd0;
      rsp_len     <= 2'd0;
      byte_idx    <= 2'd0;
      rx_cnt      <= 1'b0;
      timer       <= '0;
    end else begin
      TX_DATA     <= tx_data_nxt;
      TX_VALID    <= tx_valid_nxt;
      RSP_DATA    <= rsp_data_nxt;
      RSP_VALID   <= rsp_valid_nxt;
      TIMEOUT_ERR <= timeout_err_nxt;
      BUSY        <= (state_nxt != IDLE);
      CMD_READY   <= (state_nxt == IDLE);
      last_idx    <= last_idx_nxt;
      rsp_len     <= rsp_len_nxt;
      byte_idx    <= byte_idx_nxt;
      rx_cnt      <= rx_cnt_nxt;
      timer       <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_sys_cmd_host.sv
// Directed bench for sys_cmd_host. Two instances share all inputs: "dut" uses
// a 64-cycle response timeout, "dut_t" a 16-cycle one for the timeout cases.
module tb_sys_cmd_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_fun;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        cmd_ready, tx_valid, rsp_valid, timeout_err, busy;
  logic [7:0]  tx_data;
  logic [15:0] rsp_data;
  logic        t_cmd_ready, t_tx_valid, t_rsp_valid, t_timeout_err, t_busy;
  logic [7:0]  t_tx_data;
  logic [15:0] t_rsp_data;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  got  [8];
  logic [7:0]  expb [4];
  int          ngot;
  int          tx_cycles;
  bit          stable_ok;

  always #5 clk = ~clk;

  sys_cmd_host #(.TIMEOUT_CYCLES(64), .TMR_WIDTH(7)) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_A(cmd_a), .CMD_B(cmd_b),
    .CMD_FUN(cmd_fun), .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RSP_DATA(rsp_data), .RSP_VALID(rsp_valid),
    .TIMEOUT_ERR(timeout_err), .BUSY(busy)
  );

  sys_cmd_host #(.TIMEOUT_CYCLES(16), .TMR_WIDTH(5)) dut_t (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(t_cmd_ready),
    .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_A(cmd_a), .CMD_B(cmd_b),
    .CMD_FUN(cmd_fun), .TX_DATA(t_tx_data), .TX_VALID(t_tx_valid), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RSP_DATA(t_rsp_data), .RSP_VALID(t_rsp_valid),
    .TIMEOUT_ERR(t_timeout_err), .BUSY(t_busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a command once CMD_READY is seen, then scramble the fields.
  task automatic send_cmd(input logic [1:0] ty, input logic [3:0] ad,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
    end
    cmd_type = ty; cmd_addr = ad; cmd_a = a; cmd_b = b; cmd_fun = fn;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    cmd_type = ~ty; cmd_addr = ~ad; cmd_a = ~a; cmd_b = ~b; cmd_fun = ~fn;
  endtask

  // Record bytes from TX handshakes until n are seen (bounded).
  task automatic run_tx(input int n, input bit rand_rdy, input bit rx_junk);
    bit         prev_stall;
    logic [7:0] prev_data;
    int         cyc;
    ngot = 0; stable_ok = 1'b1; prev_stall = 1'b0; prev_data = 8'h00; cyc = 0;
    while (ngot < n && cyc < 300) begin
      tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_valid = rx_junk;
      rx_data  = 8'h77;
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stable_ok = 1'b0;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        got[ngot] = tx_data;
        ngot++;
      end
      prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_data  = tx_data;
      tick;
      cyc++;
    end
    tx_cycles = cyc;
    rx_valid  = 1'b0;
    tx_ready  = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = 4'd0; cmd_a = 8'd0;
    cmd_b = 8'd0; cmd_fun = 4'd0; tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    repeat (3) tick;
    checks++;
    if ({cmd_ready, tx_valid, busy, rsp_valid, timeout_err, tx_data, rsp_data} !== {1'b1, 28'h0}) begin
      errors++;
      $display("FAIL reset_state got=%b%b%b%b%b %h %h exp=10000 00 0000",
               cmd_ready, tx_valid, busy, rsp_valid, timeout_err, tx_data, rsp_data);
    end
    rst = 1'b1;
    tx_ready = 1'b1;
    tick;
    checks++;
    if ({t_cmd_ready, t_tx_valid, t_busy, t_rsp_valid, t_timeout_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_state_t got=%b%b%b%b%b exp=10000",
               t_cmd_ready, t_tx_valid, t_busy, t_rsp_valid, t_timeout_err);
    end
  endtask

  task automatic test_rf_wr;
    send_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
    checks++;
    if ({tx_valid, busy, cmd_ready, tx_data} !== {3'b110, 8'hAA}) begin
      errors++;
      $display("FAIL t1_first got=%b%b%b %h exp=110 aa", tx_valid, busy, cmd_ready, tx_data);
    end
    run_tx(3, 1'b0, 1'b0);
    expb[0] = 8'hAA; expb[1] = 8'h05; expb[2] = 8'h3C;
    checks++;
    if (tx_cycles !== 3 || ngot !== 3) begin
      errors++;
      $display("FAIL t1_cycles got=%0d/%0d exp=3/3", ngot, tx_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== expb[i]) begin
        errors++;
        $display("FAIL t1_byte%0d got=%h exp=%h", i, got[i], expb[i]);
      end
    end
    checks++;
    if ({rsp_valid, rsp_data, cmd_ready, busy, tx_valid} !== {1'b1, 16'h0000, 3'b100}) begin
      errors++;
      $display("FAIL t1_done got=%b %h %b%b%b exp=1 0000 100", rsp_valid, rsp_data, cmd_ready, busy, tx_valid);
    end
    tick;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_pulse_width got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    send_cmd(2'd0, 4'h1, 8'h10, 8'h00, 4'h0);
    run_tx(3, 1'b0, 1'b0);
    // Next command offered in the RSP_VALID pulse cycle, where CMD_READY is already 1.
    cmd_type = 2'd1; cmd_addr = 4'h3; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0; cmd_type = 2'd2; cmd_addr = 4'hC;
    checks++;
    if ({tx_valid, tx_data, rsp_valid} !== {1'b1, 8'hBB, 1'b0}) begin
      errors++;
      $display("FAIL b2b_accept got=%b %h %b exp=1 bb 0", tx_valid, tx_data, rsp_valid);
    end
    run_tx(2, 1'b0, 1'b0);
    checks++;
    if ({got[0], got[1]} !== 16'hBB03) begin
      errors++;
      $display("FAIL b2b_bytes got=%h%h exp=bb03", got[0], got[1]);
    end
    rx_valid = 1'b1; rx_data = 8'h5E;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 16'h005E}) begin
      errors++;
      $display("FAIL b2b_rsp got=%b %h exp=1 005e", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_rf_rd;
    int pulses;
    send_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
    run_tx(2, 1'b0, 1'b0);
    checks++;
    if ({got[0], got[1], tx_valid, busy} !== {16'hBB02, 2'b01}) begin
      errors++;
      $display("FAIL t2_send got=%h%h %b%b exp=bb02 01", got[0], got[1], tx_valid, busy);
    end
    pulses = 0;
    for (int k = 0; k < 49; k++) begin
      tick;
      if (rsp_valid === 1'b1 || timeout_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL t2_early_pulse got=%0d exp=0", pulses);
    end
    rx_valid = 1'b1; rx_data = 8'h81;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data, busy, cmd_ready} !== {1'b1, 16'h0081, 2'b01}) begin
      errors++;
      $display("FAIL t2_rsp got=%b %h %b%b exp=1 0081 01", rsp_valid, rsp_data, busy, cmd_ready);
    end
    tick;
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b0, 16'h0081}) begin
      errors++;
      $display("FAIL t2_hold got=%b %h exp=0 0081", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_alu_op;
    send_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h1);
    run_tx(4, 1'b0, 1'b1);
    expb[0] = 8'hCC; expb[1] = 8'h12; expb[2] = 8'h34; expb[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== expb[i]) begin
        errors++;
        $display("FAIL t3_byte%0d got=%h exp=%h", i, got[i], expb[i]);
      end
    end
    rx_valid = 1'b1; rx_data = 8'hCD;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({rsp_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL t3_mid got=%b%b exp=01", rsp_valid, busy);
    end
    repeat (3) tick;
    rx_valid = 1'b1; rx_data = 8'hAB;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 16'hABCD}) begin
      errors++;
      $display("FAIL t3_rsp got=%b %h exp=1 abcd", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_tx_stall;
    send_cmd(2'd2, 4'h0, 8'h5A, 8'hA5, 4'hF);
    checks++;
    if (rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL t4_rsp_clear got=%h exp=0000", rsp_data);
    end
    run_tx(4, 1'b1, 1'b0);
    expb[0] = 8'hCC; expb[1] = 8'h5A; expb[2] = 8'hA5; expb[3] = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== expb[i]) begin
        errors++;
        $display("FAIL t4_byte%0d got=%h exp=%h", i, got[i], expb[i]);
      end
    end
    checks++;
    if (stable_ok !== 1'b1) begin
      errors++;
      $display("FAIL t4_stable got=%b exp=1", stable_ok);
    end
    rx_valid = 1'b1; rx_data = 8'h01;
    tick;
    rx_data = 8'h02;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 16'h0201}) begin
      errors++;
      $display("FAIL t4_rsp got=%b %h exp=1 0201", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_timeout;
    int t_at, m_at, t_cnt, m_cnt, rsp_cnt;
    logic [1:0] t_ctl;
    checks++;
    if (t_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL t5_pre_ready got=%b exp=1", t_cmd_ready);
    end
    send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h3);
    run_tx(2, 1'b0, 1'b0);
    checks++;
    if ({got[0], got[1]} !== 16'hDD03) begin
      errors++;
      $display("FAIL t5_bytes got=%h%h exp=dd03", got[0], got[1]);
    end
    rx_valid = 1'b1; rx_data = 8'h42;
    tick;
    rx_valid = 1'b0;
    t_at = 0; m_at = 0; t_cnt = 0; m_cnt = 0; rsp_cnt = 0; t_ctl = 2'b00;
    for (int k = 1; k <= 70; k++) begin
      tick;
      if (t_timeout_err === 1'b1) begin t_at = k; t_cnt++; end
      if (timeout_err === 1'b1) begin m_at = k; m_cnt++; end
      if (rsp_valid === 1'b1 || t_rsp_valid === 1'b1) rsp_cnt++;
      if (k == 16) t_ctl = {t_cmd_ready, t_busy};
    end
    checks++;
    if (t_at !== 16 || t_cnt !== 1) begin
      errors++;
      $display("FAIL t5_timeout16 got=cycle %0d count %0d exp=cycle 16 count 1", t_at, t_cnt);
    end
    checks++;
    if (m_at !== 64 || m_cnt !== 1) begin
      errors++;
      $display("FAIL t5_timeout64 got=cycle %0d count %0d exp=cycle 64 count 1", m_at, m_cnt);
    end
    checks++;
    if (t_ctl !== 2'b10 || rsp_cnt !== 0) begin
      errors++;
      $display("FAIL t5_ctl got=%b rsp=%0d exp=10 rsp=0", t_ctl, rsp_cnt);
    end
  endtask

  task automatic test_rx_at_expiry;
    send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h7);
    run_tx(2, 1'b0, 1'b0);
    repeat (15) tick;
    rx_valid = 1'b1; rx_data = 8'h11;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({t_timeout_err, t_busy} !== 2'b01) begin
      errors++;
      $display("FAIL t5b_expiry got=%b%b exp=01", t_timeout_err, t_busy);
    end
    rx_valid = 1'b1; rx_data = 8'h22;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({t_rsp_valid, t_rsp_data, rsp_valid, rsp_data} !== {1'b1, 16'h2211, 1'b1, 16'h2211}) begin
      errors++;
      $display("FAIL t5b_rsp got=%b %h %b %h exp=1 2211 1 2211", t_rsp_valid, t_rsp_data, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    send_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h1);
    run_tx(2, 1'b0, 1'b0);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h34}) begin
      errors++;
      $display("FAIL t6_pre got=%b %h exp=1 34", tx_valid, tx_data);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    checks++;
    if ({tx_valid, busy, cmd_ready, rsp_valid, timeout_err, tx_data} !== {5'b00100, 8'h00}) begin
      errors++;
      $display("FAIL t6_abort got=%b%b%b%b%b %h exp=00100 00",
               tx_valid, busy, cmd_ready, rsp_valid, timeout_err, tx_data);
    end
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (rsp_valid === 1'b1 || timeout_err === 1'b1 || tx_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL t6_quiet got=%0d exp=0", pulses);
    end
    send_cmd(2'd1, 4'hF, 8'h00, 8'h00, 4'h0);
    run_tx(2, 1'b0, 1'b0);
    checks++;
    if ({got[0], got[1]} !== 16'hBB0F) begin
      errors++;
      $display("FAIL t6_bytes got=%h%h exp=bb0f", got[0], got[1]);
    end
    rx_valid = 1'b1; rx_data = 8'h99;
    tick;
    rx_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 16'h0099}) begin
      errors++;
      $display("FAIL t6_rsp got=%b %h exp=1 0099", rsp_valid, rsp_data);
    end
  endtask

  initial begin
    test_reset;
    test_rf_wr;
    test_back_to_back;
    test_rf_rd;
    test_alu_op;
    test_tx_stall;
    test_timeout;
    test_rx_at_expiry;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
